// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_BAD_DATA = 32'hDEADBEEF;
  localparam int          LANES         = 4;

endpackage

// File: rtl/dmem_bank.sv
// Synchronous byte-lane-writable RAM, 2^ADDR_W words of 32 bits, registered read.
// Read is read-first: dout shows the word as it was before a same-edge write.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Per-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= din[8*i +: 8];
    end
    dout <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-port responder: accepts one request at a time, waits LATENCY
// cycles, then performs the access and releases the pipeline stall.
// Optional macro DMEM_BOUNDS_CHK_EN: requests with address bits above the array
// are flagged (sticky addr_err), writes are dropped and reads return DEADBEEF.
// Without it, upper address bits are ignored and the index wraps.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         SINGLE = (LATENCY == 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              bad_q;
  logic [31:0]       rdata_q;
  logic              addr_err_q;

  logic [ADDR_W-1:0] idx_live;
  logic              bad_live;
  logic [ADDR_W-1:0] idx_b;
  logic [3:0]        sel_b;
  logic [31:0]       wdata_b;
  logic              bad_b;
  logic              access;
  logic [3:0]        we;
  logic [31:0]       dout;
  logic [31:0]       rd_val;
  logic              unused_addr;

  assign idx_live = addr[ADDR_W+1:2];
`ifdef DMEM_BOUNDS_CHK_EN
  assign bad_live = |addr[31:ADDR_W+2];
`else
  assign bad_live = 1'b0;
`endif
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // In IDLE the latch is being loaded this edge, so a single-cycle access
  // uses the live request; every later access uses the latched copy.
  assign idx_b   = (state == IDLE) ? idx_live : idx_q;
  assign sel_b   = (state == IDLE) ? sel      : sel_q;
  assign wdata_b = (state == IDLE) ? wdata    : wdata_q;
  assign bad_b   = (state == IDLE) ? bad_live : bad_q;

  assign access = (SINGLE && state == IDLE && memen) ||
                  (state == BUSY && memen && cnt == 4'd1);
  assign we     = (access && !bad_b) ? sel_b : 4'b0000;

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk  (clk),
    .we   (we),
    .idx  (idx_b),
    .din  (wdata_b),
    .dout (dout)
  );

  // Bank dout carries the read word during DONE; afterwards rdata_q holds it.
  assign rd_val   = bad_q ? DMEM_BAD_DATA : dout;
  assign rdata    = (state == DONE && sel_q == 4'b0000) ? rd_val : rdata_q;
  assign stall    = ~rst & memen & (state != DONE);
  assign addr_err = addr_err_q;

  // Request sequencer: latch, count down the wait, complete, then return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sel_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      bad_q      <= 1'b0;
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      if (access && bad_b) addr_err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (memen) begin
            sel_q   <= sel;
            idx_q   <= idx_live;
            wdata_q <= wdata;
            bad_q   <= bad_live;
            cnt     <= LAT_M1;
            state   <= SINGLE ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (!memen)             state <= IDLE;
          else if (cnt == 4'd1)   state <= DONE;
        end
        DONE: begin
          if (sel_q == 4'b0000) rdata_q <= rd_val;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver issues requests and pushes the
// reference model's expectation; a monitor pops and checks at each DONE cycle.
module tb_dmem_responder;

  parameter int LATENCY = 2;
  localparam int ADDR_W = 10;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        memen;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        addr_err;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .rst      (rst),
    .memen    (memen),
    .sel      (sel),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [16];
  logic        err_m;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHK_EN
    return (a >> (ADDR_W + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: word index wraps modulo 2^ADDR_W; bench keeps it below 16.
  task automatic model_req(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   w;
    w = int'((a >> 2) & ((32'd1 << ADDR_W) - 1));
    e.is_rd = (s == 4'b0000);
    e.data  = 32'h0;
    if (is_bad(a)) begin
      err_m = 1'b1;
      if (e.is_rd) e.data = BAD;
    end else if (e.is_rd) begin
      e.data = mem_m[w];
    end else begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[w][8*i +: 8] = d[8*i +: 8];
    end
    e.err = err_m;
    sb.push_back(e);
  endtask

  // mode 0: complete normally, 1: drop memen in first BUSY cycle, 2: reset in BUSY.
  task automatic run_req(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                         input int mode);
    int n;
    @(negedge clk);
    memen = 1'b1; sel = s; addr = a; wdata = d;
    if (mode == 0) begin
      model_req(s, a, d);
      n = 0;
      #1;
      while (stall && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (stall) begin
        errors++;
        $display("FAIL done_timeout actual=stall_high_40_cycles required=done");
      end
    end else if (mode == 1) begin
      @(negedge clk);
      memen = 1'b0;
    end else begin
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
      memen = 1'b0;
      err_m = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      memen = 1'b0;
    end
  endtask

  // Monitor: count stall cycles per request and check each completion.
  int run = 0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        run = 0;
      end else if (memen && stall) begin
        run++;
      end else if (memen && !stall) begin
        chk("latency", run, LATENCY);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=no_pending_request");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_rd) chk("rdata", rdata, e.data);
          chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
        end
        run = 0;
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          m;
    rst = 1'b1; memen = 1'b1; sel = 4'h0; addr = 32'h0; wdata = 32'h0;
    err_m = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    #2;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_addr_err", {31'd0, addr_err}, 32'd0);
    memen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) run_req(4'hF, 32'(w) << 2, 32'h0, 0);
    idle(1);

    run_req(4'hF, 32'h10, 32'h12345678, 0);
    idle(1);
    run_req(4'h0, 32'h10, 32'h0, 0);
    run_req(4'b0100, 32'h10, 32'h00AB0000, 0);
    run_req(4'h0, 32'h10, 32'h0, 0);
    idle(2);

    if (LATENCY > 1) begin
      run_req(4'hF, 32'h20, 32'hFFFFFFFF, 1);
      run_req(4'h0, 32'h20, 32'h0, 0);
      idle(1);
      run_req(4'hF, 32'h24, 32'hCAFEF00D, 2);
      idle(1);
      run_req(4'h0, 32'h24, 32'h0, 0);
      idle(1);
    end

    run_req(4'h0, 32'h00001000, 32'h0, 0);
    run_req(4'hF, 32'h00001000, 32'h55555555, 0);
    run_req(4'h0, 32'h00000000, 32'h0, 0);
    idle(1);

    for (int k = 0; k < 300; k++) begin
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hFFFFF000);
      s = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
      m = $urandom_range(0, 99);
      if (LATENCY > 1 && m < 5)       run_req(s, a, $urandom, 1);
      else if (LATENCY > 1 && m < 7)  run_req(s, a, $urandom, 2);
      else                            run_req(s, a, $urandom, 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
